// File: rtl/pillar_animator_if.sv
// Pixel-port and handshake bundle between the game-state controller, the pillar
// animator and the shared VGA plotter.
interface pillar_animator_if;
    logic       startAnimation;
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] colour;
    logic       plot;
    logic       doneAnimation;
    logic [7:0] riseOffset;

    // The controller side drives the request and consumes the plot stream.
    modport master (
        output startAnimation,
        input  x,
        input  y,
        input  colour,
        input  plot,
        input  doneAnimation,
        input  riseOffset
    );

    modport slave (
        input  startAnimation,
        output x,
        output y,
        output colour,
        output plot,
        output doneAnimation,
        output riseOffset
    );
endinterface

// File: rtl/pillar_animator.sv
// Frame-paced rising-pillar animator: one row per step, then a pacing wait.
// Optional edge shading is enabled by defining PILLAR_SHADE_EN.
module pillar_animator #(
    parameter logic [8:0] PILLAR_X0     = 9'd150,
    parameter int         PILLAR_W      = 12,
    parameter logic [7:0] BASE_Y        = 8'd200,
    parameter int         RISE          = 40,
    parameter int         FRAME_TICKS   = 833333,
    parameter logic [8:0] PILLAR_COLOUR = 9'h1B6,
    parameter logic [8:0] EDGE_COLOUR   = 9'h092
) (
    input  logic              clock,
    input  logic              resetn,
    pillar_animator_if.slave  anim
);

    localparam logic [7:0]  COL_LAST   = 8'(PILLAR_W - 1);
    localparam logic [19:0] FRAME_LAST = 20'(FRAME_TICKS - 1);
    localparam logic [7:0]  STEP_LAST  = 8'(RISE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      stateReg;
    logic [7:0]  colReg;
    logic [19:0] frameReg;
    logic [7:0]  stepReg;
    logic [7:0]  riseReg;

    logic        plotting;
    logic        edgePixel;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stateReg <= IDLE;
            colReg   <= 8'd0;
            frameReg <= 20'd0;
            stepReg  <= 8'd0;
            riseReg  <= 8'd0;
        end else begin
            case (stateReg)
                IDLE: begin
                    // riseOffset keeps the last completed height until a new run starts
                    if (anim.startAnimation) begin
                        stateReg <= DRAW;
                        colReg   <= 8'd0;
                        frameReg <= 20'd0;
                        stepReg  <= 8'd0;
                        riseReg  <= 8'd0;
                    end
                end
                DRAW: begin
                    if (!anim.startAnimation) begin
                        stateReg <= IDLE;
                        colReg   <= 8'd0;
                        frameReg <= 20'd0;
                        stepReg  <= 8'd0;
                        riseReg  <= 8'd0;
                    end else if (colReg == COL_LAST) begin
                        colReg   <= 8'd0;
                        stateReg <= WAIT;
                    end else begin
                        colReg <= colReg + 8'd1;
                    end
                end
                WAIT: begin
                    // Abort is tested first so it beats a coincident frame completion
                    if (!anim.startAnimation) begin
                        stateReg <= IDLE;
                        colReg   <= 8'd0;
                        frameReg <= 20'd0;
                        stepReg  <= 8'd0;
                        riseReg  <= 8'd0;
                    end else if (frameReg == FRAME_LAST) begin
                        frameReg <= 20'd0;
                        riseReg  <= riseReg + 8'd1;
                        if (stepReg == STEP_LAST) begin
                            stateReg <= DONE;
                        end else begin
                            stepReg  <= stepReg + 8'd1;
                            stateReg <= DRAW;
                        end
                    end else begin
                        frameReg <= frameReg + 20'd1;
                    end
                end
                DONE: begin
                    if (!anim.startAnimation) begin
                        stateReg <= IDLE;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

`ifdef PILLAR_SHADE_EN
    assign edgePixel = (colReg == 8'd0) || (colReg == COL_LAST);
`else
    assign edgePixel = 1'b0;
`endif

    // Pixel outputs are parked at zero whenever no pixel is being written.
    assign plotting           = (stateReg == DRAW);
    assign anim.plot          = plotting;
    assign anim.x             = plotting ? (PILLAR_X0 + {1'b0, colReg}) : 9'd0;
    assign anim.y             = plotting ? (BASE_Y - stepReg) : 8'd0;
    assign anim.colour        = !plotting ? 9'd0 : (edgePixel ? EDGE_COLOUR : PILLAR_COLOUR);
    assign anim.doneAnimation = (stateReg == DONE);
    assign anim.riseOffset    = riseReg;

endmodule
